// File: rtl/router_pkg.sv
// Shared types and defaults for the packet-buffer port arbiter.
package router_pkg;

  localparam int DEFAULT_NUM_REQ       = 4;
  localparam int DEFAULT_ADDR_WIDTH    = 10;
  localparam int DEFAULT_NUMBER_PACKET = 19;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    XFER    = 2'b01,
    RELEASE = 2'b10
  } state_t;

  typedef enum logic {
    DIR_READ  = 1'b0,
    DIR_WRITE = 1'b1
  } dir_t;

  // A one-beat burst still needs a one-bit counter.
  function automatic int beat_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first eligible client at or after i_ptr, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_elig,
  input  logic [SEL_W-1:0]   i_ptr,
  output logic               o_valid,
  output logic [SEL_W-1:0]   o_idx
);

  localparam int SW1 = SEL_W + 1;

  logic [SEL_W:0]   w_sum;
  logic [SEL_W-1:0] w_idx;

  // Scan farthest offset first so the closest eligible client is the last write.
  always_comb begin
    o_valid = |i_elig;
    o_idx   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      w_sum = {1'b0, i_ptr} + SW1'(off);
      if (w_sum >= SW1'(NUM_REQ)) begin
        w_sum = w_sum - SW1'(NUM_REQ);
      end
      w_idx = w_sum[SEL_W-1:0];
      if (i_elig[w_idx]) begin
        o_idx = w_idx;
      end
    end
  end

endmodule

// File: rtl/router_arbiter.sv
// Round-robin owner of the shared packet-buffer port; runs fixed-length bursts per grant.
module router_arbiter
  import router_pkg::*;
#(
  parameter int NUM_REQ       = DEFAULT_NUM_REQ,
  parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
  parameter int NUMBER_PACKET = DEFAULT_NUMBER_PACKET
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_read,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_src_addr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_dst_addr,
  output logic [NUM_REQ-1:0]            gnt_read,
  output logic [NUM_REQ-1:0]            gnt_write,
  output logic [NUM_REQ-1:0]            xfer_done,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_rd_en,
  output logic                          mem_wr_en,
  output logic [$clog2(NUM_REQ)-1:0]    mem_sel,
  output logic                          busy
);

  localparam int SEL_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = beat_width(NUMBER_PACKET);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUMBER_PACKET - 1);

  state_t              r_state, w_state_nxt;
  dir_t                r_dir, w_dir_nxt;
  logic [SEL_W-1:0]    r_owner, w_owner_nxt, r_rr_ptr, w_pick_idx;
  logic [BEAT_W-1:0]   r_beat;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [NUM_REQ-1:0]  w_elig;
  logic                w_pick_valid, w_grant;

  logic [NUM_REQ-1:0]  r_gnt_read, r_gnt_write, r_done;
  logic [NUM_REQ-1:0]  w_gnt_read_nxt, w_gnt_write_nxt, w_done_nxt;
  logic                r_rd_en, r_wr_en, r_busy, w_rd_en_nxt, w_wr_en_nxt;

  assign w_elig  = req_read | req_write;
  assign w_grant = (r_state == IDLE) && w_pick_valid;

  rr_picker #(.NUM_REQ(NUM_REQ), .SEL_W(SEL_W)) u_picker (
    .i_elig  (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_valid) w_state_nxt = XFER;
      XFER:    if (r_beat == LAST_BEAT) w_state_nxt = RELEASE;
      RELEASE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be flopped and still line up with it.
  always_comb begin
    w_owner_nxt     = r_owner;
    w_dir_nxt       = r_dir;
    w_gnt_read_nxt  = '0;
    w_gnt_write_nxt = '0;
    w_done_nxt      = '0;
    w_rd_en_nxt     = 1'b0;
    w_wr_en_nxt     = 1'b0;
    if (w_grant) begin
      w_owner_nxt = w_pick_idx;
      w_dir_nxt   = req_read[w_pick_idx] ? DIR_READ : DIR_WRITE;
    end
    case (w_state_nxt)
      XFER: begin
        if (w_dir_nxt == DIR_READ) begin
          w_gnt_read_nxt[w_owner_nxt] = 1'b1;
          w_rd_en_nxt = 1'b1;
        end else begin
          w_gnt_write_nxt[w_owner_nxt] = 1'b1;
          w_wr_en_nxt = 1'b1;
        end
      end
      RELEASE: w_done_nxt[w_owner_nxt] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= '0;
      r_dir       <= DIR_READ;
      r_rr_ptr    <= '0;
      r_beat      <= '0;
      r_addr      <= '0;
      r_gnt_read  <= '0;
      r_gnt_write <= '0;
      r_done      <= '0;
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_owner     <= w_owner_nxt;
      r_dir       <= w_dir_nxt;
      r_gnt_read  <= w_gnt_read_nxt;
      r_gnt_write <= w_gnt_write_nxt;
      r_done      <= w_done_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_busy      <= (w_state_nxt != IDLE);
      if (w_grant) begin
        r_rr_ptr <= (w_pick_idx == SEL_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
        r_beat   <= '0;
        r_addr   <= req_read[w_pick_idx] ? req_src_addr[w_pick_idx*ADDR_WIDTH +: ADDR_WIDTH]
                                         : req_dst_addr[w_pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
      end else if (r_state == XFER) begin
        r_beat <= r_beat + 1'b1;
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  assign gnt_read  = r_gnt_read;
  assign gnt_write = r_gnt_write;
  assign xfer_done = r_done;
  assign mem_addr  = r_addr;
  assign mem_rd_en = r_rd_en;
  assign mem_wr_en = r_wr_en;
  assign mem_sel   = r_owner;
  assign busy      = r_busy;

endmodule

// File: doc/router_arbiter.md
# router_arbiter

Round-robin arbiter that shares one packet-buffer memory port among `NUM_REQ` router controllers. Each controller raises a read or write request with source/destination addresses. The arbiter grants one owner at a time and drives a fixed-length burst of `NUMBER_PACKET` memory beats on that owner's behalf. It then signals completion and releases the port. It sits between the per-router controllers (their `arbiter_*_req`/`arbiter_*_gnt` pins) and the shared buffer/crossbar.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesting controllers (≥2)
- `ADDR_WIDTH`, 10, buffer address width
- `NUMBER_PACKET`, 19, beats per burst (≥1)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_read`  in  NUM_REQ  per-client read request, level
- `req_write`  in  NUM_REQ  per-client write request, level
- `req_src_addr`  in  NUM_REQ*ADDR_WIDTH  packed read start addresses, client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- `req_dst_addr`  in  NUM_REQ*ADDR_WIDTH  packed write start addresses, same packing
- `gnt_read`  out  NUM_REQ  one-hot read grant, high for whole burst
- `gnt_write`  out  NUM_REQ  one-hot write grant, high for whole burst
- `xfer_done`  out  NUM_REQ  one-cycle completion pulse to owner
- `mem_addr`  out  ADDR_WIDTH  shared buffer address
- `mem_rd_en`  out  1  buffer read strobe
- `mem_wr_en`  out  1  buffer write strobe
- `mem_sel`  out  $clog2(NUM_REQ)  owner index, steers crossbar
- `busy`  out  1  high in XFER and RELEASE

## Operation
- Requests are only considered in IDLE.
- Client i is eligible if `req_read[i]|req_write[i]`.
- Selection is round-robin: scan from `rr_ptr` upward, with wrap-around.
- If the selected client has both bits set, read wins. The write is served on a later round.
- At grant, latch the owner index, the direction, and the start address: `req_src_addr` slice for read, `req_dst_addr` slice for write.
- `rr_ptr` ← owner+1, mod NUM_REQ.
- States:
  - IDLE → XFER when any client is eligible.
  - XFER stays for exactly NUMBER_PACKET cycles, then → RELEASE.
  - RELEASE → IDLE unconditionally.
- In XFER:
  - The matching `gnt_*` bit is high.
  - `mem_rd_en` or `mem_wr_en` is high every cycle.
  - `mem_addr` = start + beat, truncated to ADDR_WIDTH, so it wraps 2^ADDR_WIDTH−1 → 0.
  - Beat counter is $clog2(NUMBER_PACKET) bits wide and runs 0..NUMBER_PACKET−1.
- In RELEASE:
  - `xfer_done[owner]` = 1.
  - Grants and strobes are 0.
  - The client must deassert its request on `xfer_done`. A request still high when IDLE is next entered counts as a new request.
- Deasserting a request during XFER is ignored: the burst completes and no abort exists.
- Request or address changes after grant do not affect the burst.
- Reset, including mid-burst: state IDLE, `rr_ptr`=0, all outputs 0, and the burst is dropped.

## Timing
- All outputs are registered.
- Request high in IDLE at edge k → grant, strobe, and first `mem_addr` valid from edge k+1.
- Last beat is at edge k+NUMBER_PACKET.
- `xfer_done` is high during cycle k+NUMBER_PACKET+1.
- IDLE is reached at k+NUMBER_PACKET+2; the earliest next grant is k+NUMBER_PACKET+3.
- Minimum burst-to-burst period is NUMBER_PACKET+2 cycles.
- `mem_sel` is stable from the grant edge through RELEASE. It holds the last owner in IDLE.
- Exactly one of `gnt_read`/`gnt_write` has at most one bit set. Both are zero outside XFER.
- `mem_rd_en` and `mem_wr_en` are never high simultaneously.

## Structure
- Shared package `router_pkg` holds:
  - state encoding: IDLE=2'b00, XFER=2'b01, RELEASE=2'b10
  - direction enum: DIR_READ, DIR_WRITE
  - default ADDR_WIDTH / NUMBER_PACKET constants
- One natural sub-module, `rr_picker`: combinational round-robin priority select. Inputs are the eligible vector and `rr_ptr`. Outputs are a valid flag and the winner index.
- FSM, beat counter, and address generator stay in the top module.

## Test plan
- Single read: NUM_REQ=4, client 2 `req_read`, src=0x010 → `gnt_read`=4'b0100 and `mem_sel`=2 for 19 cycles, `mem_addr` 0x010..0x022, `xfer_done[2]` on cycle 20, no write strobe.
- Fairness: all four `req_write` held high through 8 bursts → owners 0,1,2,3,0,1,2,3, each burst 21 cycles apart.
- Read/write same client: client 1 raises both → read burst first, write burst on the next round using dst addr; other clients' requests interleave in round-robin order.
- Address wrap: read src=0x3F8, ADDR_WIDTH=10 → `mem_addr` 0x3F8..0x3FF, then 0x000..0x00A.
- Request drop and address change mid-burst: deassert the request and change src at beat 5 → burst still completes with 19 beats from the latched address, and `xfer_done` still pulses.
- Reset mid-burst: `rst_n` low at beat 7 → all outputs 0 immediately; after release, a pending client 3 request is granted first (`rr_ptr`=0 scan finds 3), and the new burst runs 19 full beats.
